// File: rtl/adler32_multi.sv
// Multi-byte-per-beat Adler-32 engine: sizes a message, folds BPB bytes per beat
// into A/B mod 65521 and presents {B,A} with a one-cycle valid pulse.
module adler32_multi #(
   parameter int BPB   = 4,
   parameter int LEN_W = 22
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [LEN_W-1:0]   size,
   input  logic               size_valid,
   input  logic               data_start,
   input  logic               data_valid,
   input  logic [8*BPB-1:0]   data,
   output logic               busy,
   output logic               checksum_valid,
   output logic [31:0]        checksum,
   output logic               err
);

   // state | meaning
   // IDLE  | no message; waiting for a non-zero size strobe
   // ARMED | size captured; waiting for the start beat (size may be re-captured)
   // RUN   | consuming beats until the remaining count reaches zero
   // DONE  | final beat folded in; publish checksum next edge
   typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

   localparam logic [16:0]      MOD   = 17'd65521;
   localparam logic [LEN_W-1:0] BPB_L = LEN_W'(BPB);

   state_t            state;
   logic [15:0]       a_q, b_q, a_nx, b_nx;
   logic [16:0]       sum_a, sum_b;
   logic [LEN_W-1:0]  remaining, rem_nx, consumed;
   logic              accept, last_beat, size_ok, err_c;

   assign size_ok   = size_valid && (size != '0);
   assign accept    = ((state == ARMED) && data_start && data_valid) ||
                      ((state == RUN) && data_valid);
   assign last_beat = (remaining <= BPB_L);
   assign consumed  = last_beat ? remaining : BPB_L;
   assign rem_nx    = remaining - consumed;

   assign err_c = (size_valid && ((size == '0) || (state == RUN) || (state == DONE))) ||
                  (data_start && ((state == IDLE) || (state == RUN)));

   // The start beat is folded from the initial A=1, B=0 rather than the held registers.
   always_comb begin
      a_nx  = (state == ARMED) ? 16'd1 : a_q;
      b_nx  = (state == ARMED) ? 16'd0 : b_q;
      sum_a = '0;
      sum_b = '0;
      for (int i = 0; i < BPB; i++) begin
         if (LEN_W'(i) < remaining) begin
            sum_a = {1'b0, a_nx} + {9'd0, data[8*i +: 8]};
            if (sum_a >= MOD) sum_a = sum_a - MOD;
            a_nx  = sum_a[15:0];
            sum_b = {1'b0, b_nx} + {1'b0, a_nx};
            if (sum_b >= MOD) sum_b = sum_b - MOD;
            b_nx  = sum_b[15:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         busy           <= 1'b0;
         checksum_valid <= 1'b0;
         checksum       <= '0;
         err            <= 1'b0;
         a_q            <= 16'd1;
         b_q            <= 16'd0;
         remaining      <= '0;
      end else begin
         err            <= err_c;
         checksum_valid <= 1'b0;
         if (accept) begin
            a_q       <= a_nx;
            b_q       <= b_nx;
            remaining <= rem_nx;
         end
         case (state)
            IDLE: begin
               if (size_ok) begin
                  remaining <= size;
                  state     <= ARMED;
               end
            end
            ARMED: begin
               if (accept) begin
                  state <= last_beat ? DONE : RUN;
                  busy  <= 1'b1;
               end else if (size_ok) begin
                  remaining <= size;
               end
            end
            RUN: begin
               if (accept && last_beat) state <= DONE;
            end
            DONE: begin
               checksum       <= {b_q, a_q};
               checksum_valid <= 1'b1;
               busy           <= 1'b0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adler32_multi.sv
// Self-checking bench for adler32_multi (BPB=4) against a plain-arithmetic Adler-32 model.
module tb_adler32_multi;

   localparam int BPB   = 4;
   localparam int LEN_W = 22;
   localparam int CV_LAT = 1;  // edges after the final-beat edge until the pulse is visible

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [LEN_W-1:0]  size = '0;
   logic              size_valid = 1'b0;
   logic              data_start = 1'b0;
   logic              data_valid = 1'b0;
   logic [8*BPB-1:0]  data = '0;
   logic              busy, checksum_valid, err;
   logic [31:0]       checksum;

   int n_checks = 0;
   int n_fail   = 0;
   int cv_count = 0;

   adler32_multi #(.BPB(BPB), .LEN_W(LEN_W)) u_dut (
      .clk(clk), .rst_n(rst_n), .size(size), .size_valid(size_valid),
      .data_start(data_start), .data_valid(data_valid), .data(data),
      .busy(busy), .checksum_valid(checksum_valid), .checksum(checksum), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (checksum_valid === 1'b1) cv_count++;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] adler_ref(input logic [7:0] m[$]);
      int unsigned a = 1, b = 0;
      foreach (m[i]) begin
         a = (a + m[i]) % 65521;
         b = (b + a) % 65521;
      end
      return {b[15:0], a[15:0]};
   endfunction

   function automatic void str_to_q(input string s, output logic [7:0] q[$]);
      q = {};
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
   endfunction

   // Drives one message; reports result, pulse latency (-1 on timeout), err pulses seen.
   task automatic send_msg(input logic [7:0] msg[$], input int stall_min, input int stall_max,
                           input int dup_start_beat, input int pre_size,
                           output logic [31:0] got, output int lat, output int errs,
                           output logic busy_after);
      int len, idx, beat, k;
      bit first;
      len = msg.size(); errs = 0; lat = -1; got = '0; busy_after = 1'b1;
      if (pre_size != 0) begin
         size = LEN_W'(pre_size); size_valid = 1'b1; tick; if (err) errs++;
      end
      size = LEN_W'(len); size_valid = 1'b1; tick; if (err) errs++;
      size_valid = 1'b0;
      idx = 0; beat = 0; first = 1'b1;
      while (idx < len) begin
         if (!first) begin
            k = $urandom_range(stall_max, stall_min);
            repeat (k) begin
               data_valid = 1'b0; data_start = 1'b0; data = $urandom; tick; if (err) errs++;
            end
         end
         beat++;
         data_valid = 1'b1;
         data_start = first || (beat == dup_start_beat);
         for (int l = 0; l < BPB; l++)
            data[8*l +: 8] = (idx + l < len) ? msg[idx + l] : 8'($urandom);
         tick; if (err) errs++;
         idx += BPB; first = 1'b0;
      end
      data_valid = 1'b0; data_start = 1'b0;
      for (int c = 1; c <= 8 && lat < 0; c++) begin
         tick; if (err) errs++;
         if (checksum_valid) begin
            lat = c; got = checksum; busy_after = busy;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; tick; tick;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
      n_checks++; if (checksum_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cv got %b expected 0", checksum_valid); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b expected 0", err); end
      n_checks++; if (checksum !== 32'h0) begin n_fail++; $display("FAIL reset_checksum got %h expected 00000000", checksum); end
      rst_n = 1'b1; tick;
   endtask

   task automatic test_wiki;
      logic [7:0] q[$]; logic [31:0] got; int lat, errs, cv0; logic ba;
      str_to_q("Wikipedia", q);
      cv0 = cv_count;
      send_msg(q, 0, 0, 0, 0, got, lat, errs, ba);
      n_checks++; if (got !== 32'h11E60398) begin n_fail++; $display("FAIL wiki_checksum got %h expected 11e60398", got); end
      n_checks++; if (lat !== CV_LAT) begin n_fail++; $display("FAIL wiki_latency got %0d expected %0d", lat, CV_LAT); end
      n_checks++; if (ba !== 1'b0) begin n_fail++; $display("FAIL wiki_busy_after got %b expected 0", ba); end
      n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL wiki_err got %0d expected 0", errs); end
      tick; tick;
      n_checks++; if (cv_count - cv0 !== 1) begin n_fail++; $display("FAIL wiki_pulse_count got %0d expected 1", cv_count - cv0); end
      n_checks++; if (checksum !== 32'h11E60398) begin n_fail++; $display("FAIL wiki_hold got %h expected 11e60398", checksum); end
   endtask

   task automatic test_single_and_size0;
      logic [7:0] q[$]; logic [31:0] got; int lat, errs; logic ba;
      q = {8'h61};
      send_msg(q, 0, 0, 0, 0, got, lat, errs, ba);
      n_checks++; if (got !== 32'h00620062) begin n_fail++; $display("FAIL single_checksum got %h expected 00620062", got); end
      n_checks++; if (lat !== CV_LAT) begin n_fail++; $display("FAIL single_latency got %0d expected %0d", lat, CV_LAT); end
      tick;
      size = '0; size_valid = 1'b1; tick; size_valid = 1'b0;
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL size0_err got %b expected 1", err); end
      tick;
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL size0_err_pulse got %b expected 0", err); end
      // Still IDLE: a start beat must neither arm nor run, and flags err.
      data_start = 1'b1; data_valid = 1'b1; data = $urandom; tick;
      data_start = 1'b0; data_valid = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL size0_idle_busy got %b expected 0", busy); end
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL idle_start_err got %b expected 1", err); end
      tick; tick;
   endtask

   task automatic test_stall3;
      logic [7:0] q[$]; logic [31:0] got; int lat, errs; logic ba;
      str_to_q("Wikipedia", q);
      send_msg(q, 3, 3, 0, 0, got, lat, errs, ba);
      n_checks++; if (got !== adler_ref(q)) begin n_fail++; $display("FAIL stall3_checksum got %h expected %h", got, adler_ref(q)); end
      n_checks++; if (lat !== CV_LAT) begin n_fail++; $display("FAIL stall3_latency got %0d expected %0d", lat, CV_LAT); end
      tick;
   endtask

   task automatic test_big;
      logic [7:0] q[$]; logic [31:0] got; int lat, errs; logic ba;
      for (int i = 0; i < 100000; i++) q.push_back(8'hFF);
      send_msg(q, 0, 1, 0, 0, got, lat, errs, ba);
      n_checks++; if (got !== adler_ref(q)) begin n_fail++; $display("FAIL big_checksum got %h expected %h", got, adler_ref(q)); end
      n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL big_err got %0d expected 0", errs); end
      tick;
   endtask

   task automatic test_random;
      logic [7:0] q[$]; logic [31:0] got, exp; int lat, errs, len; logic ba;
      for (int m = 0; m < 8; m++) begin
         q = {};
         len = $urandom_range(40, 1);
         for (int i = 0; i < len; i++) q.push_back(8'($urandom));
         exp = adler_ref(q);
         send_msg(q, 0, 2, 0, 0, got, lat, errs, ba);
         n_checks++; if (got !== exp || lat !== CV_LAT) begin
            n_fail++; $display("FAIL random_msg%0d len %0d got %h lat %0d expected %h lat %0d", m, len, got, lat, exp, CV_LAT);
         end
         tick;
      end
   endtask

   task automatic test_rearm;
      logic [7:0] q[$]; logic [31:0] got; int lat, errs; logic ba;
      q = {8'($urandom), 8'($urandom), 8'($urandom)};
      send_msg(q, 0, 0, 0, 7, got, lat, errs, ba);
      n_checks++; if (got !== adler_ref(q) || lat !== CV_LAT) begin
         n_fail++; $display("FAIL rearm_checksum got %h lat %0d expected %h lat %0d", got, lat, adler_ref(q), CV_LAT);
      end
      tick;
   endtask

   task automatic test_midrun_start;
      logic [7:0] q[$]; logic [31:0] got; int lat, errs; logic ba;
      str_to_q("Wikipedia", q);
      send_msg(q, 0, 0, 2, 0, got, lat, errs, ba);
      n_checks++; if (errs !== 1) begin n_fail++; $display("FAIL midrun_start_err got %0d expected 1", errs); end
      n_checks++; if (got !== 32'h11E60398) begin n_fail++; $display("FAIL midrun_start_checksum got %h expected 11e60398", got); end
      tick;
   endtask

   task automatic test_reset_midrun;
      int cv0;
      size = LEN_W'(9); size_valid = 1'b1; tick; size_valid = 1'b0;
      data_start = 1'b1; data_valid = 1'b1; data = {"i", "k", "i", "W"}; tick;
      data_start = 1'b0; data = {"i", "d", "e", "p"};
      #2 rst_n = 1'b0; #1;
      n_checks++; if ({busy, checksum_valid, err} !== 3'b000 || checksum !== 32'h0) begin
         n_fail++; $display("FAIL reset_midrun_outputs got busy %b cv %b err %b cks %h expected 0 0 0 00000000",
                            busy, checksum_valid, err, checksum);
      end
      cv0 = cv_count;
      tick; tick; rst_n = 1'b1;
      repeat (6) begin data = $urandom; tick; end
      data_valid = 1'b0; tick; tick;
      n_checks++; if (cv_count !== cv0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_midrun_discard got pulses %0d busy %b expected 0 0", cv_count - cv0, busy);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] q1[$], q2[$]; logic [31:0] g1, g2; int l1, l2, e1, e2, cv0; logic ba;
      q1 = {8'h61};
      str_to_q("Wikipedia", q2);
      cv0 = cv_count;
      send_msg(q1, 0, 0, 0, 0, g1, l1, e1, ba);
      send_msg(q2, 0, 0, 0, 0, g2, l2, e2, ba);
      n_checks++; if (g1 !== 32'h00620062 || l1 !== CV_LAT) begin n_fail++; $display("FAIL b2b_first got %h lat %0d expected 00620062 lat %0d", g1, l1, CV_LAT); end
      n_checks++; if (g2 !== 32'h11E60398 || l2 !== CV_LAT) begin n_fail++; $display("FAIL b2b_second got %h lat %0d expected 11e60398 lat %0d", g2, l2, CV_LAT); end
      tick; tick;
      n_checks++; if (cv_count - cv0 !== 2) begin n_fail++; $display("FAIL b2b_pulses got %0d expected 2", cv_count - cv0); end
      n_checks++; if (e1 + e2 !== 0) begin n_fail++; $display("FAIL b2b_err got %0d expected 0", e1 + e2); end
   endtask

   initial begin
      test_reset;
      test_wiki;
      test_single_and_size0;
      test_stall3;
      test_random;
      test_rearm;
      test_midrun_start;
      test_back_to_back;
      test_reset_midrun;
      test_wiki;
      test_big;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
